// File: rtl/cva6_region_attr_unit.sv
// Runtime-programmable PMA region attribute unit.
// Shadow rule bank written over the cfg port; a commit copies shadow to the
// active bank once the 2-stage lookup pipeline has drained.
// Optional feature macro: CVA6_REGION_ATTR_LOCK_EN (ctrl bit4 acts as a sticky lock).
//
// state  | meaning
// IDLE   | cfg and lookups accepted
// DRAIN  | commit pending, waiting for the lookup pipe to empty
// COMMIT | one cycle copying shadow -> active
module cva6_region_attr_unit #(
  parameter int   NR_RULES     = 4,
  parameter int   ADDR_W       = 64,
  parameter logic DEFAULT_EXEC = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_req_i,
  output logic              cfg_gnt_o,
  input  logic              cfg_we_i,
  input  logic [3:0]        cfg_idx_i,
  input  logic [1:0]        cfg_field_i,
  input  logic [ADDR_W-1:0] cfg_wdata_i,
  output logic [ADDR_W-1:0] cfg_rdata_o,
  output logic              cfg_rvalid_o,
  output logic              cfg_err_o,
  input  logic              cfg_commit_i,
  output logic              cfg_busy_o,
  input  logic              lkp_valid_i,
  output logic              lkp_ready_o,
  input  logic [ADDR_W-1:0] lkp_addr_i,
  output logic              lkp_valid_o,
  input  logic              lkp_ready_i,
  output logic              lkp_hit_o,
  output logic [3:0]        lkp_idx_o,
  output logic [2:0]        lkp_attr_o
);

`ifdef CVA6_REGION_ATTR_LOCK_EN
  localparam logic [4:0] CTRL_MASK = 5'h1f;
`else
  localparam logic [4:0] CTRL_MASK = 5'h0f;
`endif

  localparam logic [ADDR_W-1:0] RST_BASE = ADDR_W'(64'h8000_0000);
  localparam logic [ADDR_W-1:0] RST_LEN  = ADDR_W'(64'h4000_0000);
  localparam logic [4:0]        RST_CTRL = 5'b01011;

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] sh_base [NR_RULES];
  logic [ADDR_W-1:0] sh_len  [NR_RULES];
  logic [4:0]        sh_ctrl [NR_RULES];
  logic [ADDR_W-1:0] ac_base [NR_RULES];
  logic [ADDR_W-1:0] ac_len  [NR_RULES];
  logic [3:0]        ac_ctrl [NR_RULES];

  logic              idle, idx_ok, sel_locked, wr_xfer, wr_bad, wr_do, rd_xfer;
  logic [ADDR_W-1:0] rd_mux;

  logic                s1_valid, s1_adv, s2_adv, accept;
  logic [NR_RULES-1:0] hit_vec, s1_hit;
  logic [2:0]          s1_attr [NR_RULES];
  logic                enc_hit;
  logic [3:0]          enc_idx;
  logic [2:0]          enc_attr;

  assign idle        = (state == IDLE);
  assign cfg_gnt_o   = idle;
  assign cfg_busy_o  = !idle;
  assign s2_adv      = !lkp_valid_o || lkp_ready_i;
  assign s1_adv      = !s1_valid || s2_adv;
  assign lkp_ready_o = idle && s1_adv;
  assign accept      = lkp_valid_i && lkp_ready_o;

  // Decode the selected shadow rule for cfg reads and write checks
  always_comb begin
    idx_ok     = ({1'b0, cfg_idx_i} < 5'(NR_RULES));
    sel_locked = 1'b0;
    rd_mux     = '0;
    for (int i = 0; i < NR_RULES; i++) begin
      if (cfg_idx_i == 4'(i)) begin
        sel_locked = sh_ctrl[i][4];
        case (cfg_field_i)
          2'd0:    rd_mux = sh_base[i];
          2'd1:    rd_mux = sh_len[i];
          2'd2:    rd_mux = ADDR_W'(sh_ctrl[i]);
          default: rd_mux = '0;
        endcase
      end
    end
  end

  // The lock bit can only be set when the lock feature is built in, so
  // sel_locked stays 0 otherwise and no lock-related error can fire.
  assign wr_xfer = cfg_req_i && cfg_gnt_o && cfg_we_i;
  assign rd_xfer = cfg_req_i && cfg_gnt_o && !cfg_we_i;
  assign wr_bad  = !idx_ok || (cfg_field_i == 2'd3) || sel_locked;
  assign wr_do   = wr_xfer && !wr_bad;

  // Shadow bank: written only by accepted, legal cfg writes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_RULES; i++) begin
        sh_base[i] <= (i == 0) ? RST_BASE : '0;
        sh_len[i]  <= (i == 0) ? RST_LEN  : '0;
        sh_ctrl[i] <= (i == 0) ? RST_CTRL : '0;
      end
    end else if (wr_do) begin
      for (int i = 0; i < NR_RULES; i++) begin
        if (cfg_idx_i == 4'(i)) begin
          case (cfg_field_i)
            2'd0:    sh_base[i] <= cfg_wdata_i;
            2'd1:    sh_len[i]  <= cfg_wdata_i;
            default: sh_ctrl[i] <= cfg_wdata_i[4:0] & CTRL_MASK;
          endcase
        end
      end
    end
  end

  // Active bank: copied from shadow in the single COMMIT cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_RULES; i++) begin
        ac_base[i] <= (i == 0) ? RST_BASE : '0;
        ac_len[i]  <= (i == 0) ? RST_LEN  : '0;
        ac_ctrl[i] <= (i == 0) ? RST_CTRL[3:0] : '0;
      end
    end else if (state == COMMIT) begin
      for (int i = 0; i < NR_RULES; i++) begin
        ac_base[i] <= sh_base[i];
        ac_len[i]  <= sh_len[i];
        ac_ctrl[i] <= sh_ctrl[i][3:0];
      end
    end
  end

  // Cfg read response and write-error pulse, one cycle after the transfer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      cfg_rvalid_o <= rd_xfer;
      cfg_err_o    <= wr_xfer && wr_bad;
      if (rd_xfer) cfg_rdata_o <= rd_mux;
    end
  end

  // Per-rule range match in ADDR_W+1 bits so base+len never wraps
  for (genvar g = 0; g < NR_RULES; g++) begin : g_match
    logic [ADDR_W:0] diff;
    assign diff       = {1'b0, lkp_addr_i} - {1'b0, ac_base[g]};
    assign hit_vec[g] = ac_ctrl[g][0] && (lkp_addr_i >= ac_base[g]) &&
                        (diff < {1'b0, ac_len[g]});
  end

  // Stage 1: capture hit vector and the active attributes at accept time
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
      for (int i = 0; i < NR_RULES; i++) s1_attr[i] <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_hit <= hit_vec;
        for (int i = 0; i < NR_RULES; i++) s1_attr[i] <= ac_ctrl[i][3:1];
      end
    end
  end

  // Lowest-index hit wins; no hit falls back to the default attributes
  always_comb begin
    enc_hit  = 1'b0;
    enc_idx  = '0;
    enc_attr = {DEFAULT_EXEC, 2'b00};
    for (int i = NR_RULES - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        enc_hit  = 1'b1;
        enc_idx  = 4'(i);
        enc_attr = s1_attr[i];
      end
    end
  end

  // Stage 2: registered result, held while downstream stalls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lkp_valid_o <= 1'b0;
      lkp_hit_o   <= 1'b0;
      lkp_idx_o   <= '0;
      lkp_attr_o  <= '0;
    end else if (s2_adv) begin
      lkp_valid_o <= s1_valid;
      if (s1_valid) begin
        lkp_hit_o  <= enc_hit;
        lkp_idx_o  <= enc_idx;
        lkp_attr_o <= enc_attr;
      end
    end
  end

  // Commit sequencer state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Commit sequencer next state; commits outside IDLE merge into the pending one
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_commit_i) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid && !lkp_valid_o) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
